// File: rtl/four_to_one_mux_sequencer.sv
// Round-robin control stage for a 4:1 mux.
// Arbitrates four request lines, drives the mux select pair, a one-hot grant
// and a valid flag. Each grant is held for at most HOLD_CYCLES cycles.
// Every output comes straight from a flop, so no request reaches an output
// combinationally.
module four_to_one_mux_sequencer #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_0,
    input  logic req_1,
    input  logic req_2,
    input  logic req_3,
    output logic s_0,
    output logic s_1,
    output logic valid,
    output logic gnt_0,
    output logic gnt_1,
    output logic gnt_2,
    output logic gnt_3
);

    // Dwell counter is wide enough to hold HOLD_CYCLES itself.
    localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Registered state and outputs.
    state_t           r_state;
    logic [1:0]       r_last;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_sel;
    logic [3:0]       r_gnt;
    logic             r_valid;

    // Next-state values and arbitration wires.
    state_t           w_state_nxt;
    logic [1:0]       w_last_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       w_sel_nxt;
    logic [3:0]       w_gnt_nxt;
    logic             w_valid_nxt;

    logic [3:0]       w_req;
    logic             w_any_req;
    logic [1:0]       w_cand;
    logic [1:0]       w_pick;
    logic             w_pick_found;
    logic             w_release;
    logic             w_do_grant;

    assign w_req     = {req_3, req_2, req_1, req_0};
    assign w_any_req = |w_req;

    // The holder gives up the grant when it drops its request or its dwell
    // budget is spent. Only meaningful in ST_GRANT, where r_last is the holder.
    assign w_release = (r_cnt == '0) || !w_req[r_last];

    // Round-robin pick: search last+1, last+2, last+3, then last itself, so
    // the most recent holder is lowest priority but can still win alone.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        w_pick_found = 1'b0;
        w_pick       = r_last;
        w_cand       = r_last;
        for (int k = 1; k <= 4; k++) begin
            w_cand = r_last + 2'(k);
            if (!w_pick_found && w_req[w_cand]) begin
                w_pick_found = 1'b1;
                w_pick       = w_cand;
            end
        end
    end

    // Next-state and next-output logic for the IDLE/GRANT controller.
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        w_sel_nxt   = r_sel;
        w_gnt_nxt   = r_gnt;
        w_valid_nxt = r_valid;
        w_do_grant  = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_do_grant = 1'b1;
                end
            end
            ST_GRANT: begin
                if (!w_release) begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end else if (w_any_req) begin
                    // Hand over in the same edge, no idle bubble.
                    w_do_grant = 1'b1;
                end else begin
                    // Selects keep the last encoding so the mux does not glitch.
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_gnt_nxt   = 4'b0000;
                    w_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_gnt_nxt   = 4'b0000;
                w_valid_nxt = 1'b0;
            end
        endcase

        if (w_do_grant) begin
            w_state_nxt = ST_GRANT;
            w_last_nxt  = w_pick;
            w_cnt_nxt   = CNT_LOAD;
            w_sel_nxt   = w_pick;
            w_gnt_nxt   = 4'b0001 << w_pick;
            w_valid_nxt = 1'b1;
        end
    end

    // State and output registers; reset favours port 0 for the first pick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values, independent of block order.
            r_state <= ST_IDLE;
            r_last  <= 2'd3;
            r_cnt   <= '0;
            r_sel   <= 2'b00;
            r_gnt   <= 4'b0000;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sel   <= w_sel_nxt;
            r_gnt   <= w_gnt_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    // s_0 carries the MSB of the granted index, s_1 the LSB.
    assign s_0   = r_sel[1];
    assign s_1   = r_sel[0];
    assign valid = r_valid;
    assign gnt_0 = r_gnt[0];
    assign gnt_1 = r_gnt[1];
    assign gnt_2 = r_gnt[2];
    assign gnt_3 = r_gnt[3];

endmodule

// File: tb/tb_four_to_one_mux_sequencer.sv
// Bench for four_to_one_mux_sequencer: one instance with HOLD_CYCLES=4 and
// one with HOLD_CYCLES=1 share clock, reset and requests. A cycle-level
// behavioural model (holder, cycles used, pointer) predicts both.
module tb_four_to_one_mux_sequencer;

    typedef struct packed {
        logic       active;
        logic [1:0] ptr;
        logic [1:0] sel;
        logic [8:0] used;
    } mstate_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;

    logic s0_a, s1_a, valid_a, g0_a, g1_a, g2_a, g3_a;
    logic s0_b, s1_b, valid_b, g0_b, g1_b, g2_b, g3_b;
    logic [6:0] out_a;
    logic [6:0] out_b;

    mstate_t m_a;
    mstate_t m_b;

    int n_checks;
    int n_errors;

    four_to_one_mux_sequencer #(.HOLD_CYCLES(4)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_0(req[0]), .req_1(req[1]), .req_2(req[2]), .req_3(req[3]),
        .s_0(s0_a), .s_1(s1_a), .valid(valid_a),
        .gnt_0(g0_a), .gnt_1(g1_a), .gnt_2(g2_a), .gnt_3(g3_a)
    );

    four_to_one_mux_sequencer #(.HOLD_CYCLES(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_0(req[0]), .req_1(req[1]), .req_2(req[2]), .req_3(req[3]),
        .s_0(s0_b), .s_1(s1_b), .valid(valid_b),
        .gnt_0(g0_b), .gnt_1(g1_b), .gnt_2(g2_b), .gnt_3(g3_b)
    );

    // Packed view: {valid, s_0, s_1, gnt_3, gnt_2, gnt_1, gnt_0}
    assign out_a = {valid_a, s0_a, s1_a, g3_a, g2_a, g1_a, g0_a};
    assign out_b = {valid_b, s0_b, s1_b, g3_b, g2_b, g1_b, g0_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock of the arbitration rules for a given hold limit.
    function automatic mstate_t model_step(mstate_t s, logic [3:0] r, int h);
        mstate_t    n;
        logic [1:0] idx;
        int         w;
        bit         rel;
        n   = s;
        w   = -1;
        rel = !s.active || !r[s.ptr] || (int'(s.used) == h);
        if (!rel) begin
            n.used = 9'(int'(s.used) + 1);
        end else begin
            for (int k = 1; k <= 4; k++) begin
                idx = 2'(int'(s.ptr) + k);
                if (w < 0 && r[idx]) w = int'(idx);
            end
            if (w >= 0) begin
                n.active = 1'b1;
                n.ptr    = 2'(w);
                n.sel    = 2'(w);
                n.used   = 9'd1;
            end else begin
                n.active = 1'b0;
                n.used   = 9'd0;
            end
        end
        return n;
    endfunction

    function automatic logic [6:0] model_out(mstate_t s);
        return {s.active, s.sel, s.active ? (4'b0001 << s.ptr) : 4'b0000};
    endfunction

    // Reference model advances on the same edges as the design.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_a <= '{active: 1'b0, ptr: 2'd3, sel: 2'd0, used: 9'd0};
            m_b <= '{active: 1'b0, ptr: 2'd3, sel: 2'd0, used: 9'd0};
        end else begin
            m_a <= model_step(m_a, req, 4);
            m_b <= model_step(m_b, req, 1);
        end
    end

    // Called at a falling edge: drive requests, let one rising edge pass,
    // return at the next falling edge where outputs are stable.
    task automatic tick(input logic [3:0] r);
        req = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        @(negedge clk);
        n_checks++;
        if (out_a !== 7'b0) begin
            n_errors++;
            $display("FAIL reset_state_h4: got %b want %b", out_a, 7'b0);
        end
        n_checks++;
        if (out_b !== 7'b0) begin
            n_errors++;
            $display("FAIL reset_state_h1: got %b want %b", out_b, 7'b0);
        end
        rst_n = 1'b1;
        tick(4'b0100);
        n_checks++;
        if (out_a !== 7'b1_10_0100) begin
            n_errors++;
            $display("FAIL reset_pre_grant2: got %b want %b", out_a, 7'b1_10_0100);
        end
        tick(4'b0100);
        // Assert reset between edges, mid-grant of port 2.
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_a !== 7'b0) begin
            n_errors++;
            $display("FAIL reset_async_h4: got %b want %b", out_a, 7'b0);
        end
        n_checks++;
        if (out_b !== 7'b0) begin
            n_errors++;
            $display("FAIL reset_async_h1: got %b want %b", out_b, 7'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick(4'b1111);
        n_checks++;
        if (out_a !== 7'b1_00_0001) begin
            n_errors++;
            $display("FAIL reset_first_pick_h4: got %b want %b", out_a, 7'b1_00_0001);
        end
        n_checks++;
        if (out_b !== 7'b1_00_0001) begin
            n_errors++;
            $display("FAIL reset_first_pick_h1: got %b want %b", out_b, 7'b1_00_0001);
        end
    endtask

    task automatic test_rotation();
        logic [6:0] want;
        int         p;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            tick(4'b1111);
            p    = i / 4;
            want = {1'b1, 2'(p), 4'b0001 << p};
            n_checks++;
            if (out_a !== want) begin
                n_errors++;
                $display("FAIL rotation_h4 cyc%0d: got %b want %b", i, out_a, want);
            end
            n_checks++;
            if (out_b !== model_out(m_b)) begin
                n_errors++;
                $display("FAIL rotation_h1 cyc%0d: got %b want %b", i, out_b, model_out(m_b));
            end
        end
    endtask

    task automatic test_early_release();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick(i < 2 ? 4'b0010 : 4'b0000);
            n_checks++;
            if (out_a !== (i < 2 ? 7'b1_01_0010 : 7'b0_01_0000)) begin
                n_errors++;
                $display("FAIL early_release_h4 cyc%0d: got %b want %b", i, out_a,
                         (i < 2 ? 7'b1_01_0010 : 7'b0_01_0000));
            end
            n_checks++;
            if (out_b !== model_out(m_b)) begin
                n_errors++;
                $display("FAIL early_release_h1 cyc%0d: got %b want %b", i, out_b, model_out(m_b));
            end
        end
    endtask

    task automatic test_sole_requester();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick(4'b1000);
            n_checks++;
            if (out_a !== 7'b1_11_1000) begin
                n_errors++;
                $display("FAIL sole_req_h4 cyc%0d: got %b want %b", i, out_a, 7'b1_11_1000);
            end
            n_checks++;
            if (out_b !== 7'b1_11_1000) begin
                n_errors++;
                $display("FAIL sole_req_h1 cyc%0d: got %b want %b", i, out_b, 7'b1_11_1000);
            end
        end
    endtask

    task automatic test_pointer_fairness();
        do_reset();
        tick(4'b0100);
        tick(4'b0100);
        tick(4'b0000);
        n_checks++;
        if (out_a !== 7'b0_10_0000) begin
            n_errors++;
            $display("FAIL fairness_idle_h4: got %b want %b", out_a, 7'b0_10_0000);
        end
        tick(4'b1001);
        n_checks++;
        if (out_a !== 7'b1_11_1000) begin
            n_errors++;
            $display("FAIL fairness_pick_h4: got %b want %b", out_a, 7'b1_11_1000);
        end
        n_checks++;
        if (out_b !== 7'b1_11_1000) begin
            n_errors++;
            $display("FAIL fairness_pick_h1: got %b want %b", out_b, 7'b1_11_1000);
        end
    endtask

    task automatic test_single_cycle_dwell();
        logic [6:0] want;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            tick(4'b0101);
            want = (i % 2 == 0) ? 7'b1_00_0001 : 7'b1_10_0100;
            n_checks++;
            if (out_b !== want) begin
                n_errors++;
                $display("FAIL dwell1_h1 cyc%0d: got %b want %b", i, out_b, want);
            end
            n_checks++;
            if (out_a !== model_out(m_a)) begin
                n_errors++;
                $display("FAIL dwell1_h4 cyc%0d: got %b want %b", i, out_a, model_out(m_a));
            end
        end
    endtask

    task automatic test_back_to_back_random();
        logic [3:0] r;
        do_reset();
        r = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            // Each line flips with probability 1/4 so requests persist a while.
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(3, 0) == 0) r[b] = ~r[b];
            end
            tick(r);
            n_checks++;
            if (out_a !== model_out(m_a)) begin
                n_errors++;
                $display("FAIL random_h4 cyc%0d req=%b: got %b want %b", i, r, out_a, model_out(m_a));
            end
            n_checks++;
            if (out_b !== model_out(m_b)) begin
                n_errors++;
                $display("FAIL random_h1 cyc%0d req=%b: got %b want %b", i, r, out_b, model_out(m_b));
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        req      = 4'b0000;
        test_reset();
        test_rotation();
        test_early_release();
        test_sole_requester();
        test_pointer_fairness();
        test_single_cycle_dwell();
        test_back_to_back_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/four_to_one_mux_sequencer.md
# four_to_one_mux_sequencer

Upstream control stage for `four_to_one_mux`. It arbitrates four request lines round-robin and drives the mux select pair `s_0`/`s_1`, plus a one-hot grant and a valid flag. Each grant lasts at most `HOLD_CYCLES` cycles. The mux data path stays purely combinational; all sequencing lives here.

## Interface
- `HOLD_CYCLES`, default 4: maximum consecutive cycles one port keeps the grant (legal range 1..255).
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  reset; **asynchronous, active-low**.
- `req_0`..`req_3`  input  1 each  request from source feeding mux port `p_0`..`p_3`.
- `s_0`  output  1  mux select, MSB of granted port index.
- `s_1`  output  1  mux select, LSB of granted port index.
- `valid`  output  1  high while a port holds the grant (mux `OUT` meaningful).
- `gnt_0`..`gnt_3`  output  1 each  one-hot grant; all zero when `valid`=0.

## Operation
- Select encoding is fixed to match the mux:
  - port 0 → `s_0`=0, `s_1`=0
  - port 1 → `s_0`=0, `s_1`=1
  - port 2 → `s_0`=1, `s_1`=0
  - port 3 → `s_0`=1, `s_1`=1
- Internal state:
  - 2-bit `last` pointer (most recently granted port).
  - Dwell counter, width ceil(log2(HOLD_CYCLES+1)).
  - FSM with states IDLE and GRANT.
- **Round-robin pick**: search order is `last`+1, `last`+2, `last`+3, `last` (mod 4). The first asserted request wins. The current holder is therefore lowest priority, but is re-granted when it is the only requester.
- **IDLE**:
  - If any `req_i`=1 at an edge: pick winner, go to GRANT, set `last`=winner, load counter = HOLD_CYCLES-1.
  - Otherwise stay in IDLE.
- **GRANT** (holder h), release condition = `req_h`=0 OR counter==0:
  - Not releasing: decrement counter, outputs unchanged.
  - Releasing with any request pending: re-arbitrate in the same edge, switch directly to the new winner (no idle bubble), reload counter.
  - Releasing with no request pending: go to IDLE.
- **In IDLE**: `s_0`/`s_1` hold the last granted encoding so the mux does not glitch; `valid`=0; all `gnt`=0.
- **Invariants**:
  - Exactly one `gnt_i` is high when `valid`=1.
  - {`s_0`,`s_1`} always equals the binary index of the high `gnt_i`.

## Timing
- All outputs are registered; there is no combinational path from `req` to any output.
- **Grant latency**: a request sampled high at edge N gives `valid`/`gnt`/selects at edge N from IDLE, visible in cycle N+1.
- **Dwell**: a continuously requesting holder with competitors present keeps the grant for exactly HOLD_CYCLES cycles.
- **Early release**: holder deasserts `req` in cycle k → the grant changes or drops at the edge ending cycle k. At most one cycle of stale grant.
- **HOLD_CYCLES=1**: re-arbitrates every cycle, giving pure per-cycle round-robin.
- **Simultaneous requests**: resolved purely by pointer order; never by fixed priority except immediately after reset.
- **Reset (asynchronous assert, any time including mid-grant)**:
  - `valid`=0, all `gnt`=0, `s_0`=0, `s_1`=0
  - FSM=IDLE, counter=0, `last`=3 (first pick favours port 0)
- **Reset deassertion**: takes effect at the next rising edge; requests are first sampled at that edge.

## Test plan
- **Reset**: `rst_n`=0 mid-grant of port 2 → outputs go immediately to `valid`=0, `gnt`=0000, `s_0`=`s_1`=0, without waiting for a clock edge. After release with all `req`=1 → port 0 granted first, `s_0`=0, `s_1`=0.
- **Rotation**: HOLD_CYCLES=4, all four `req` held high for 16 cycles → grants 0,1,2,3, each exactly 4 cycles. Selects step 00,01,10,11 (shown as `s_0`,`s_1`). `valid` stays 1 throughout.
- **Early release**: only `req_1` high for 2 cycles, then drops → `valid`=1 with `s_0`=0, `s_1`=1 for 2 cycles, then `valid`=0 while selects stay 0,1.
- **Sole requester**: `req_3` alone held high for 10 cycles → continuous grant 3 with no gap at the dwell boundary.
- **Pointer fairness**: after port 2 releases, assert `req_0` and `req_3` together → port 3 wins.
- **Single-cycle dwell**: HOLD_CYCLES=1, `req_0` and `req_2` high → grant alternates 0,2,0,2 on every cycle.
